// File: rtl/time_pkg.sv
// Shared timekeeping constants and types.
// Imported by the time counter and by the chime/display blocks so all
// agree on field widths and wrap points.
package time_pkg;

  localparam int TW       = 7;   // width of each H/M/S field
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {RUN, HOLD, LOAD} state_e;

  // True when a requested time is a legal time of day. Arguments are full
  // 32-bit so wide out-of-range requests are rejected rather than truncated.
  function automatic logic time_in_range(input int unsigned h,
                                         input int unsigned m,
                                         input int unsigned s);
    return (h <= HOUR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
  endfunction

endpackage

// File: rtl/time_counter_tick_gen.sv
// Prescaler: divides clk down to a one-cycle tick every CLK_HZ enabled
// cycles.
//   clk, rst_n : clock, async active-low reset
//   en         : advance the prescaler this cycle
//   clr        : force the prescaler back to 0 (takes priority over en)
//   tick       : combinational, high on the enabled terminal-count cycle
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr)   cnt_q <= '0;
    else if (en)    cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/time_counter.sv
// HH:MM:SS timekeeping core with run/hold control and a validated
// time-set handshake.
//   clk, rst_n        : clock, async active-low reset
//   run               : 1 = count, 0 = hold (level)
//   set_valid/ready   : set request handshake
//   set_h/m/s         : requested time
//   set_ack / set_err : one-cycle accept / reject pulses
//   H_out/M_out/S_out : current time
//   tick_1hz          : pulses with each seconds update
//   hour_carry        : pulses on the MM:SS 59:59 -> 00:00 wrap
module time_counter
  import time_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int W      = TW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         set_valid,
  output logic         set_ready,
  input  logic [W-1:0] set_h,
  input  logic [W-1:0] set_m,
  input  logic [W-1:0] set_s,
  output logic         set_ack,
  output logic         set_err,
  output logic [W-1:0] S_out,
  output logic [W-1:0] M_out,
  output logic [W-1:0] H_out,
  output logic         tick_1hz,
  output logic         hour_carry
);

  localparam logic [W-1:0] S_TOP = W'(SEC_MAX);
  localparam logic [W-1:0] M_TOP = W'(MIN_MAX);
  localparam logic [W-1:0] H_TOP = W'(HOUR_MAX);

  state_e state_q, state_d;
  logic   ready_q;      // low only until the first edge after reset
  logic   hs, in_rng, accept, reject;
  logic   cnt_en, tick;
  logic   s_wrap, m_wrap, h_wrap;

  assign in_rng = time_in_range(32'(set_h), 32'(set_m), 32'(set_s));
  assign hs     = set_valid && set_ready;
  assign accept = hs && in_rng;
  assign reject = hs && !in_rng;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: an accepted set always wins; otherwise run selects RUN/HOLD
  // from any state, which also covers the LOAD exit.
  always_comb begin
    state_d = state_q;
    if (accept)   state_d = LOAD;
    else if (run) state_d = RUN;
    else          state_d = HOLD;
  end

  // Outputs of the FSM. The prescaler advances whenever the machine is
  // heading into RUN, so run=0 or a set on the terminal cycle suppresses
  // the increment, and LOAD with run=1 already counts its first cycle.
  always_comb begin
    set_ready = ready_q && (state_q != LOAD);
    cnt_en    = (state_d == RUN);
  end

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (accept),
    .tick  (tick)
  );

  assign s_wrap = (S_out == S_TOP);
  assign m_wrap = s_wrap && (M_out == M_TOP);
  assign h_wrap = m_wrap && (H_out == H_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      S_out      <= '0;
      M_out      <= '0;
      H_out      <= '0;
      set_ack    <= 1'b0;
      set_err    <= 1'b0;
      tick_1hz   <= 1'b0;
      hour_carry <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      set_ack    <= accept;
      set_err    <= reject;
      tick_1hz   <= tick;
      hour_carry <= tick && m_wrap;
      if (accept) begin
        S_out <= set_s;
        M_out <= set_m;
        H_out <= set_h;
      end else if (tick) begin
        S_out <= s_wrap ? '0 : S_out + 1'b1;
        if (s_wrap) M_out <= m_wrap ? '0 : M_out + 1'b1;
        if (m_wrap) H_out <= h_wrap ? '0 : H_out + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
module tb_time_counter;

  localparam int CLK_HZ = 10;
  localparam int W      = 7;

  logic         clk = 1'b0, rst_n = 1'b0, run = 1'b1, set_valid = 1'b0;
  logic [W-1:0] set_h = '0, set_m = '0, set_s = '0;
  logic         set_ready, set_ack, set_err, tick_1hz, hour_carry;
  logic [W-1:0] S_out, M_out, H_out;

  time_counter #(.CLK_HZ(CLK_HZ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .set_ack(set_ack), .set_err(set_err),
    .S_out(S_out), .M_out(M_out), .H_out(H_out),
    .tick_1hz(tick_1hz), .hour_carry(hour_carry)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_carry = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time held as seconds-of-day, prescaler as a plain count.
  int m_t = 0, m_pc = 0;
  bit m_rdyf = 0, m_loaded = 0, m_ack = 0, m_err = 0, m_tick = 0, m_carry = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_pc = 0; m_rdyf = 0; m_loaded = 0;
      m_ack = 0; m_err = 0; m_tick = 0; m_carry = 0;
    end else begin
      bit hs, ok;
      m_ack = 0; m_err = 0; m_tick = 0; m_carry = 0;
      hs = set_valid && m_rdyf && !m_loaded;
      ok = (set_h <= 23) && (set_m <= 59) && (set_s <= 59);
      if (hs && ok) begin
        m_t = set_h * 3600 + set_m * 60 + set_s;
        m_pc = 0; m_ack = 1; m_loaded = 1;
      end else begin
        m_loaded = 0;
        m_err = hs;
        if (run) begin
          if (m_pc == CLK_HZ - 1) begin
            m_pc = 0;
            m_t = (m_t + 1) % 86400;
            m_tick = 1;
            m_carry = (m_t % 3600 == 0);
          end else m_pc++;
        end
      end
      m_rdyf = 1;
    end
  end

  always @(negedge clk) begin
    check("S",     32'(S_out),      m_t % 60);
    check("M",     32'(M_out),      (m_t / 60) % 60);
    check("H",     32'(H_out),      m_t / 3600);
    check("tick",  32'(tick_1hz),   32'(m_tick));
    check("carry", 32'(hour_carry), 32'(m_carry));
    check("ack",   32'(set_ack),    32'(m_ack));
    check("err",   32'(set_err),    32'(m_err));
    check("ready", 32'(set_ready),  32'(m_rdyf && !m_loaded));
    if (hour_carry) n_carry++;
  end

  task automatic do_set(input int h, input int m, input int s);
    set_h = W'(h); set_m = W'(m); set_s = W'(s); set_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    set_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_S", 32'(S_out), 0);
    check("rst_ready", 32'(set_ready), 0);
    rst_n = 1'b1;

    // First increment 10 cycles after release, first minute after 600
    repeat (10) @(posedge clk); @(negedge clk);
    check("first_S", 32'(S_out), 1);
    check("first_tick", 32'(tick_1hz), 1);
    repeat (590) @(posedge clk); @(negedge clk);
    check("min_M", 32'(M_out), 1);
    check("min_S", 32'(S_out), 0);

    // Day wrap from 23:59:58
    n_carry = 0;
    do_set(23, 59, 58);
    check("set_ack", 32'(set_ack), 1);
    check("set_H", 32'(H_out), 23);
    check("set_M", 32'(M_out), 59);
    check("set_S", 32'(S_out), 58);
    repeat (20) @(posedge clk); @(negedge clk);
    check("wrap_H", 32'(H_out), 0);
    check("wrap_M", 32'(M_out), 0);
    check("wrap_S", 32'(S_out), 0);
    @(negedge clk); #1;
    check("carry_count", 32'(n_carry), 1);

    // Out-of-range seconds
    @(negedge clk);
    do_set(1, 2, 60);
    check("rej_err", 32'(set_err), 1);
    check("rej_ack", 32'(set_ack), 0);
    check("rej_ready", 32'(set_ready), 1);
    check("rej_H", 32'(H_out), 0);
    check("rej_M", 32'(M_out), 0);

    // Hold with prescaler partway through
    for (int i = 0; i < 200 && S_out != 5; i++) @(negedge clk);
    check("reach_S5", 32'(S_out), 5);
    repeat (4) @(negedge clk);
    run = 1'b0;
    repeat (37) @(negedge clk);
    check("hold_S", 32'(S_out), 5);
    run = 1'b1;
    repeat (5) @(posedge clk); @(negedge clk);
    check("resume_S_early", 32'(S_out), 5);
    @(posedge clk); @(negedge clk);
    check("resume_S", 32'(S_out), 6);

    // Set lands on the terminal-count cycle
    for (int i = 0; i < 50 && m_pc != CLK_HZ - 1; i++) @(negedge clk);
    check("reach_tc", 32'(m_pc), CLK_HZ - 1);
    do_set(0, 10, 0);
    check("tc_M", 32'(M_out), 10);
    check("tc_S", 32'(S_out), 0);
    check("tc_tick", 32'(tick_1hz), 0);
    repeat (9) @(posedge clk); @(negedge clk);
    check("tc_S_9", 32'(S_out), 0);
    @(posedge clk); @(negedge clk);
    check("tc_S_10", 32'(S_out), 1);

    // Async reset mid-count
    do_set(12, 34, 56);
    check("pre_rst_H", 32'(H_out), 12);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_S", 32'(S_out), 0);
    check("arst_M", 32'(M_out), 0);
    check("arst_H", 32'(H_out), 0);
    check("arst_ready", 32'(set_ready), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk); @(negedge clk);
    check("rerun_S", 32'(S_out), 1);
    check("rerun_H", 32'(H_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
